// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares the CPU bus between the CPU, the OAM DMA and DMC sample fetches.
// Halts the CPU through cpu_rdy. Sequences reads and writes on GET/PUT parity, advancing only on cpu_clk_en.
// Optional feature: define DMA_DMC_PREEMPT_EN to let a DMC fetch interrupt a running OAM DMA.
module dma_bus_arbiter #(
    parameter logic [15:0] OAM_REG_ADDR = 16'h2004,
    parameter int          OAM_COUNT    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_clk_en,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        oam_req,
    input  logic [7:0]  oam_page,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic [1:0]  bus_owner,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
    output logic        oam_busy
);
    localparam int IW = $clog2(OAM_COUNT);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, OAM_RD, OAM_WR, DMC_RD} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            parity;      // 0 = GET cycle, 1 = PUT cycle
    logic            oam_pend;
    logic [7:0]      page_q;
    logic [7:0]      oam_byte;
    logic [IW-1:0]   idx;
    logic            dmc_go;
    logic            oam_last;

    // A request still high during its own ack cycle is the old request, not a new one.
    assign dmc_go   = dmc_req & ~dmc_ack;
    // OAM_COUNT is a power of two, so the last index is all ones.
    assign oam_last = (idx == '1);
    assign oam_busy = oam_pend;

    // State register and GET/PUT parity; both advance once per CPU cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            parity <= 1'b0;
        end else if (cpu_clk_en) begin
            state  <= state_nxt;
            parity <= ~parity;
        end
    end

    // Next-state decision; parity=1 means the following cycle is a GET.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // The CPU can only be halted on a read; writes keep the bus.
                if ((oam_pend | dmc_go) & cpu_rw) state_nxt = HALT;
            end
            HALT, ALIGN: begin
                if (!parity)       state_nxt = ALIGN;
                else if (dmc_go)   state_nxt = DMC_RD;
                else if (oam_pend) state_nxt = OAM_RD;
                else               state_nxt = IDLE;
            end
            OAM_RD: state_nxt = OAM_WR;
            OAM_WR: begin
`ifdef DMA_DMC_PREEMPT_EN
                if (dmc_go)         state_nxt = DMC_RD;
                else if (!oam_last) state_nxt = OAM_RD;
                else                state_nxt = IDLE;
`else
                if (!oam_last)      state_nxt = OAM_RD;
                else if (dmc_go)    state_nxt = DMC_RD;
                else                state_nxt = IDLE;
`endif
            end
            DMC_RD: state_nxt = oam_pend ? ALIGN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus mux and CPU halt, decoded from the current state.
    always_comb begin
        cpu_rdy   = 1'b0;
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_we    = 1'b0;
        bus_owner = 2'd0;
        case (state)
            IDLE: begin
                cpu_rdy = 1'b1;
                bus_we  = ~cpu_rw;
            end
            HALT, ALIGN: begin
                // Dummy read of the CPU address while waiting for a GET slot.
                bus_owner = oam_pend ? 2'd1 : 2'd2;
            end
            OAM_RD: begin
                bus_owner = 2'd1;
                bus_addr  = {page_q, 8'(idx)};
            end
            OAM_WR: begin
                bus_owner = 2'd1;
                bus_addr  = OAM_REG_ADDR;
                bus_wdata = oam_byte;
                bus_we    = 1'b1;
            end
            DMC_RD: begin
                bus_owner = 2'd2;
                bus_addr  = dmc_addr;
            end
            default: begin
                cpu_rdy = 1'b1;
            end
        endcase
    end

    // OAM request latch, byte index and the byte carried from read to write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oam_pend <= 1'b0;
            page_q   <= 8'd0;
            oam_byte <= 8'd0;
            idx      <= '0;
        end else if (cpu_clk_en) begin
            if (state == OAM_RD) oam_byte <= mem_rdata;
            if (state == OAM_WR) begin
                idx <= idx + 1'b1;
                if (oam_last) oam_pend <= 1'b0;
            end else if (oam_req && !oam_pend) begin
                // A second request while busy is dropped without touching the page.
                oam_pend <= 1'b1;
                page_q   <= oam_page;
            end
        end
    end

    // DMC fetch result: data captured at the end of DMC_RD, ack for the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmc_ack  <= 1'b0;
            dmc_data <= 8'd0;
        end else if (cpu_clk_en) begin
            dmc_ack <= (state == DMC_RD);
            if (state == DMC_RD) dmc_data <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: random memory, pages, addresses and cpu_clk_en gaps.
// Each run is logged cycle by cycle and the log is judged against the cycle-cost and ordering rules.
module tb_dma_bus_arbiter;
`ifdef DMA_DMC_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_clk_en;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        oam_req;
    logic [7:0]  oam_page;
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic [7:0]  mem_rdata;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic [1:0]  bus_owner;
    logic        dmc_ack;
    logic [7:0]  dmc_data;
    logic        oam_busy;

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[bus_addr];

    typedef struct packed {
        logic        rdy;
        logic [1:0]  owner;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        ack;
        logic [7:0]  ddata;
        logic        busy;
        logic        par;
    } smp_t;

    smp_t log_q[$];
    logic par;
    int   checks = 0;
    int   errors = 0;

    dma_bus_arbiter dut (
        .clk(clk), .rst(rst), .cpu_clk_en(cpu_clk_en), .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .oam_req(oam_req), .oam_page(oam_page),
        .dmc_req(dmc_req), .dmc_addr(dmc_addr), .mem_rdata(mem_rdata),
        .cpu_rdy(cpu_rdy), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_owner(bus_owner), .dmc_ack(dmc_ack), .dmc_data(dmc_data), .oam_busy(oam_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: strobe cpu_clk_en, log outputs on the falling edge, then 0-1 idle clocks.
    task automatic step();
        smp_t s;
        cpu_clk_en = 1'b1;
        @(negedge clk);
        s.rdy = cpu_rdy;  s.owner = bus_owner; s.addr = bus_addr; s.we = bus_we;
        s.wdata = bus_wdata; s.ack = dmc_ack; s.ddata = dmc_data; s.busy = oam_busy; s.par = par;
        log_q.push_back(s);
        @(posedge clk); #1;
        cpu_clk_en = 1'b0;
        par = ~par;
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    endtask

    task automatic idle_tail(input string tag);
        int bad;
        bad = 0;
        repeat (4) begin
            step();
            if (!log_q[$].rdy || log_q[$].busy || log_q[$].ack) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // OAM DMA run. n_wr CPU writes accompany the request; with_dmc raises a DMC fetch once
    // 0x40 bytes are written; rst_at >= 0 resets the block once that many bytes are written.
    task automatic run_oam(input logic [7:0] page, input int req_par, input int n_wr,
                           input bit with_dmc, input int rst_at);
        smp_t        s;
        int          c, hp, exp_halt, halted, first_halt, wr_seen, wr_k, viol;
        int          dmc_pos, rd_idx, rd_par, acks, ack_idx, budget, dup;
        logic [7:0]  ack_val;
        logic [7:0]  cw [0:3];
        logic [15:0] daddr;
        bit          raised, done, was_rst;
        int          p_req;
        cpu_rw = 1'b1;
        cpu_addr = 16'h0100 | 16'($urandom_range(0, 255));
        if (req_par < 0) repeat ($urandom_range(0, 2)) step();
        else while (int'(par) != req_par) step();
        log_q.delete();
        p_req = int'(par);
        daddr = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
        wr_seen = 0; dmc_pos = -1; rd_idx = -1; rd_par = -1; acks = 0; ack_idx = -1;
        ack_val = 8'h00; dup = 0; raised = 1'b0; done = 1'b0; was_rst = 1'b0;
        oam_page = page;
        oam_req = 1'b1;
        for (int w = 0; w < n_wr; w++) begin
            cpu_rw = 1'b0; cpu_addr = 16'h0300 + 16'(w);
            cw[w] = 8'($urandom); cpu_wdata = cw[w];
            step();
            oam_req = 1'b0;
        end
        if (n_wr == 0) begin step(); oam_req = 1'b0; end
        cpu_rw = 1'b1;
        cpu_addr = 16'h0100 | 16'($urandom_range(0, 255));
        c = (n_wr > 0) ? n_wr : 1;          // first CPU read cycle with the request pending
        budget = 2000;
        while (!done && !was_rst && budget > 0) begin
            step();
            budget--;
            s = log_q[$];
            if (dup == 1) begin oam_req = 1'b0; dup = 2; end
            if (s.we && !s.rdy) wr_seen++;
            if (s.owner == 2'd2 && !s.we && !s.rdy && s.addr == daddr) begin
                dmc_pos = wr_seen; rd_idx = log_q.size() - 1; rd_par = int'(s.par);
            end
            if (s.ack) begin acks++; ack_val = s.ddata; ack_idx = log_q.size() - 1; dmc_req = 1'b0; end
            if (with_dmc && !raised && wr_seen == 'h40) begin
                dmc_req = 1'b1; dmc_addr = daddr; raised = 1'b1;
            end
            if (dup == 0 && wr_seen == 'h20) begin oam_req = 1'b1; oam_page = ~page; dup = 1; end
            if (rst_at >= 0 && wr_seen == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_rdy", cpu_rdy, 1);
                chk("rst_mid_owner", bus_owner, 0);
                chk("rst_mid_busy", oam_busy, 0);
                chk("rst_mid_ack", dmc_ack, 0);
                chk("rst_mid_ddata", dmc_data, 0);
                oam_req = 1'b0; dmc_req = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                par = 1'b0;
                was_rst = 1'b1;
            end
            if (s.rdy && log_q.size() > c + 2) done = 1'b1;
        end
        if (!was_rst) begin
            chk("oam_done", done, 1);
            hp = p_req ^ ((c + 1) & 1);
            exp_halt = 512 + ((hp == 0) ? 2 : 1) + (with_dmc ? (PREEMPT ? 2 : 1) : 0);
            halted = 0; first_halt = -1; viol = 0; wr_k = 0;
            foreach (log_q[i]) begin
                if (!log_q[i].rdy) begin
                    halted++;
                    if (first_halt < 0) first_halt = i;
                end
                if ((log_q[i].owner == 2'd0) != log_q[i].rdy) viol++;
                if (log_q[i].we && !log_q[i].rdy) begin
                    chk("oam_wr", {log_q[i].addr, log_q[i].wdata}, {16'h2004, mem[{page, 8'(wr_k)}]});
                    wr_k++;
                end
            end
            for (int w = 0; w < n_wr; w++)
                chk("cpu_wr", {log_q[w].we, log_q[w].rdy, log_q[w].addr, log_q[w].wdata},
                    {1'b1, 1'b1, 16'h0300 + 16'(w), cw[w]});
            chk("halt_cycles", halted, exp_halt);
            chk("halt_start", first_halt, c + 1);
            chk("oam_wr_count", wr_k, 256);
            chk("rdy_owner_sync", viol, 0);
            if (with_dmc) begin
                chk("dmc_pos", dmc_pos, PREEMPT ? 'h41 : 256);
                chk("dmc_rd_get", rd_par, 0);
                chk("dmc_acks", acks, 1);
                chk("dmc_ack_next", ack_idx, rd_idx + 1);
                chk("dmc_data", ack_val, mem[daddr]);
            end else begin
                chk("no_dmc_ack", acks, 0);
            end
            idle_tail("oam_idle_after");
        end
    endtask

    // Stand-alone DMC fetch from an idle, reading CPU.
    task automatic run_dmc(input logic [15:0] a, input int req_par);
        smp_t s;
        int   p_req, exp_halt, halted, rd_idx, rd_par, ack_idx, acks, budget, viol;
        logic [7:0] ack_val;
        bit   done;
        cpu_rw = 1'b1;
        cpu_addr = 16'h0100 | 16'($urandom_range(0, 255));
        while (int'(par) != req_par) step();
        log_q.delete();
        p_req = int'(par);
        rd_idx = -1; rd_par = -1; ack_idx = -1; acks = 0; ack_val = 8'h00; done = 1'b0;
        dmc_req = 1'b1; dmc_addr = a;
        budget = 50;
        while (!done && budget > 0) begin
            step();
            budget--;
            s = log_q[$];
            if (s.owner == 2'd2 && !s.rdy && !s.we && s.addr == a) begin
                rd_idx = log_q.size() - 1; rd_par = int'(s.par);
            end
            if (s.ack) begin
                acks++; ack_val = s.ddata; ack_idx = log_q.size() - 1;
                dmc_req = 1'b0; done = 1'b1;
            end
        end
        chk("dmc_done", done, 1);
        // Request on GET halts on PUT: HALT, DMC_RD. Otherwise HALT, ALIGN, DMC_RD.
        exp_halt = (p_req == 0) ? 2 : 3;
        halted = 0; viol = 0;
        foreach (log_q[i]) begin
            if (!log_q[i].rdy) halted++;
            if ((log_q[i].owner == 2'd0) != log_q[i].rdy) viol++;
        end
        chk("dmc_halt_cycles", halted, exp_halt);
        chk("dmc_rd_idx", rd_idx, exp_halt);
        chk("dmc_rd_get", rd_par, 0);
        chk("dmc_ack_next", ack_idx, rd_idx + 1);
        chk("dmc_data", ack_val, mem[a]);
        chk("dmc_rdy_back", {log_q[$].rdy, log_q[$].owner}, {1'b1, 2'd0});
        chk("dmc_rdy_owner_sync", viol, 0);
        idle_tail("dmc_idle_after");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1; cpu_clk_en = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h00;
        oam_req = 1'b0; oam_page = 8'h00; dmc_req = 1'b0; dmc_addr = 16'h0000;
        par = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", cpu_rdy, 1);
        chk("reset_owner", bus_owner, 0);
        chk("reset_we", bus_we, 0);
        chk("reset_ack", dmc_ack, 0);
        chk("reset_ddata", dmc_data, 0);
        chk("reset_busy", oam_busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_oam(8'h02, 0, 0, 1'b0, -1);                       // halt on GET
        run_oam(8'h02, 1, 0, 1'b0, -1);                       // halt on PUT
        run_dmc(16'hC000, 0);
        run_dmc(16'hC000 | 16'($urandom_range(0, 16'h3FFF)), 1);
        run_oam(8'($urandom_range(0, 255)), -1, 0, 1'b1, -1); // DMC at index 0x40
        run_oam(8'($urandom_range(0, 255)), -1, 2, 1'b0, -1); // request during 2 CPU writes
        run_oam(8'($urandom_range(0, 255)), -1, 0, 1'b0, 'h80);
        run_oam(8'($urandom_range(0, 255)), -1, 0, 1'b0, -1); // restart from index 0
        run_oam(8'($urandom_range(0, 255)), -1, 3, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
